int_sub: RTL and testbench

- 64-bit unsigned integer subtractor for the integer execution path: computes res = a - b with a borrow-out flag.
- Datapath is a combinational ripple-borrow chain of full-subtractor bit cells, followed by one output register stage.
- Sits behind the issue stage and feeds the common data bus as a 1-cycle-latency functional unit.

---
 rtl/int_sub.sv | 52 +++++
 tb/tb_int_sub.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/int_sub.sv
// Unsigned WIDTH-bit subtractor (res = a - b, bout = borrow out) built from a ripple-borrow chain of bit cells.
// Latency: 1 cycle, registered outputs; one operand pair accepted every cycle.
// Backpressure: none; the unit never stalls, and a result is valid for exactly the cycle after in_valid.
module int_sub #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] res,
    output logic             bout
);

    // Borrow chain: w_br[i] is the borrow into cell i, w_br[WIDTH] is the final borrow out.
    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] w_diff;

    logic             r_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_bout;

    assign w_br[0] = 1'b0;

    // One full-subtractor cell per bit, rippling the borrow from LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign w_diff[i]   = a[i] ^ b[i] ^ w_br[i];
        assign w_br[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_br[i]);
    end

    // Output stage: capture the result on a valid cycle, otherwise keep the old result and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_bout  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_res  <= w_diff;
                r_bout <= w_br[WIDTH];
            end
        end
    end

    assign out_valid = r_valid;
    assign res       = r_res;
    assign bout      = r_bout;

endmodule

// File: tb/tb_int_sub.sv
// Scoreboard bench for int_sub: the stimulus process queues the expected {bout,res} for each operand pair.
// The monitor pops one entry and compares it whenever out_valid is high at a falling clock edge.
// Directed vectors carry hand-computed results; the random phase uses a 65-bit golden subtraction.
module tb_int_sub;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] res;
    logic         bout;

    logic [W:0]   sb[$];
    int           checks;
    int           errors;

    int_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .res       (res),
        .bout      (bout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one valid operand pair just after a rising edge and queue its expected result.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic eb, input logic [W-1:0] er);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sb.push_back({eb, er});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got res %h bout %b with nothing expected", res, bout);
            end else begin
                chk("result", {bout, res}, sb.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   gold;
        int           wait_cyc;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        // Reset state
        #2;
        chk("rst_valid", {64'd0, out_valid}, 65'd0);
        chk("rst_res",   {1'b0, res},       65'd0);
        chk("rst_bout",  {64'd0, bout},     65'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Basic, then hold with in_valid low
        send(64'h14, 64'h4, 1'b0, 64'h10);
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("hold_valid", {64'd0, out_valid}, 65'd0);
        chk("hold_res",   {1'b0, res},       65'h10);
        chk("hold_bout",  {64'd0, bout},     65'd0);

        // Asynchronous reset between edges clears outputs at once
        #2 rst_n = 1'b0;
        #1;
        chk("arst_res",   {1'b0, res},       65'd0);
        chk("arst_valid", {64'd0, out_valid}, 65'd0);
        chk("arst_bout",  {64'd0, bout},     65'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_res", {1'b0, res}, 65'd0);
        #2 rst_n = 1'b1;

        // Underflow, equal operands, full borrow ripple, boundaries
        send(64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        send(64'h5, 64'h5, 1'b0, 64'h0);
        send(64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF);
        send(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h2);
        send(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        send(64'hDEAD_BEEF_0000_0000, 64'hDEAD_BEEF_0000_0000, 1'b0, 64'h0);
        send(64'h1_0000_0000, 64'h1, 1'b0, 64'hFFFF_FFFF);

        // Back-to-back pipeline
        send(64'h14, 64'h4, 1'b0, 64'h10);
        send(64'h3,  64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        send(64'hFF, 64'h1, 1'b0, 64'hFE);
        idle();
        repeat (3) @(negedge clk);

        // Pipeline with reset pulsed while the third pair is being sampled
        send(64'h14, 64'h4, 1'b0, 64'h10);
        send(64'h3,  64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        send(64'hFF, 64'h1, 1'b0, 64'hFE);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {64'd0, out_valid}, 65'd0);
        chk("mid_rst_res",   {1'b0, res},       65'd0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(posedge clk);
        #2 in_valid = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", {64'd0, out_valid}, 65'd0);
        end
        chk("post_rst_res", {1'b0, res}, 65'd0);

        // Random pairs against a 65-bit golden subtraction
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = (i % 16 == 0) ? ra : {$urandom, $urandom};
            if (i % 7 == 0) rb = rb >> $urandom_range(63, 1);
            gold = {1'b0, ra} - {1'b0, rb};
            send(ra, rb, gold[W], gold[W-1:0]);
        end
        idle();

        // Drain the scoreboard with a bounded wait
        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        chk("drain", 65'(sb.size()), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
